// File: rtl/led_flow_pkg.sv
// Shared mode encodings and prescaler sizing for the LED running-light controller.
package led_flow_pkg;

    localparam logic [1:0] MODE_ROT_L    = 2'b00;
    localparam logic [1:0] MODE_ROT_R    = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_BLINK    = 2'b11;

    // Clock cycles per automatic step; divide first so 32 bits never overflow.
    function automatic logic [31:0] calc_tick_div(input logic [31:0] clk_hz,
                                                  input logic [31:0] step_ms);
        return (clk_hz / 32'd1000) * step_ms;
    endfunction

endpackage

// File: rtl/led_flow_ctrl_tick_gen.sv
// Prescaler: counts 0..DIV-1 while run is high and emits a one-cycle registered tick.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int W = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_chk
        $error("tick_gen: DIV must be at least 2");
    end

    logic [W-1:0] cnt;

    // Dropping run discards any partial count, so the next tick is a full DIV away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == W'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_flow_ctrl.sv
// Running-light LED controller: prescaled auto-step or manual step, four pattern modes.
module led_flow_ctrl
    import led_flow_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 51_000_000,
    parameter int unsigned STEP_MS        = 250,
    parameter int unsigned N_LED          = 8,
    parameter int unsigned LED_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             step_req,
    output logic             tick,
    output logic [N_LED-1:0] led
);

    localparam logic [31:0]      TICK_DIV = calc_tick_div(CLK_HZ, STEP_MS);
    localparam logic [N_LED-1:0] POL      = {N_LED{LED_ACTIVE_LOW != 0}};

    if (N_LED < 2) begin : g_nled_chk
        $error("led_flow_ctrl: N_LED must be at least 2");
    end

    logic [N_LED-1:0] pat, pat_nx;
    logic             dir, dir_nx;
    logic             phase, phase_nx;
    logic             adv;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (pll_lock & en),
        .tick  (tick)
    );

    assign adv = pll_lock & ((en & tick) | (~en & step_req));

    always_comb begin
        pat_nx   = pat;
        dir_nx   = dir;
        phase_nx = phase;
        if (adv) begin
            case (mode)
                MODE_ROT_L: pat_nx = {pat[N_LED-2:0], pat[N_LED-1]};
                MODE_ROT_R: pat_nx = {pat[0], pat[N_LED-1:1]};
                MODE_PINGPONG: begin
                    // Turn around on the end LED so it is shown for only one step.
                    if (!dir) begin
                        if (pat[N_LED-1]) begin
                            dir_nx = 1'b1;
                            pat_nx = pat >> 1;
                        end else begin
                            pat_nx = pat << 1;
                        end
                    end else begin
                        if (pat[0]) begin
                            dir_nx = 1'b0;
                            pat_nx = pat << 1;
                        end else begin
                            pat_nx = pat >> 1;
                        end
                    end
                end
                default: phase_nx = ~phase;
            endcase
        end
    end

    // led is built from next-state values so a step shows on the cycle after adv.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat   <= N_LED'(1);
            dir   <= 1'b0;
            phase <= 1'b0;
            led   <= N_LED'(1) ^ POL;
        end else begin
            pat   <= pat_nx;
            dir   <= dir_nx;
            phase <= phase_nx;
            led   <= ((mode == MODE_BLINK) ? {N_LED{phase_nx}} : pat_nx) ^ POL;
        end
    end

endmodule
